// File: rtl/keypad_scanner.sv
// keypad_scanner: 4-row x 3-column keypad scanner, debouncer and key encoder.
// Optional macro KEY_REPEAT_EN adds auto-repeat strobes while a key stays held.

module keypad_scanner #(
   parameter int SCAN_DIV        = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key,
   output logic       shift
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
`endif

   if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_badParams
      $error("keypad_scanner: parameter out of range");
   end

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      EMIT,
      RELEASE
   } state_t;

   state_t            r_state;
   logic [2:0]        r_colMeta;
   logic [2:0]        r_colSync;
   logic [DIV_W-1:0]  r_div;
   logic [DB_W-1:0]   r_dbCnt;
   logic [3:0]        r_row;
   logic [1:0]        r_capRow;
   logic [1:0]        r_capColIdx;
   logic [2:0]        r_capPat;
   logic [3:0]        r_key;
   logic              r_shift;
`ifdef KEY_REPEAT_EN
   logic [REP_W-1:0]  r_repCnt;
`endif

   logic              w_colValid;
   logic [1:0]        w_colIdx;
   logic [1:0]        w_rowIdx;
   logic [3:0]        w_rowNext;
   logic [3:0]        w_code;

   assign row_out    = r_row;
   assign key        = r_key;
   assign shift      = r_shift;
   assign w_rowNext  = {r_row[2:0], r_row[3]};
   assign w_colValid = (r_colSync == 3'b001) || (r_colSync == 3'b010) || (r_colSync == 3'b100);

   always_comb begin
      w_colIdx = 2'd0;
      case (r_colSync)
         3'b010:  w_colIdx = 2'd1;
         3'b100:  w_colIdx = 2'd2;
         default: w_colIdx = 2'd0;
      endcase
   end

   always_comb begin
      w_rowIdx = 2'd0;
      case (r_row)
         4'b0010: w_rowIdx = 2'd1;
         4'b0100: w_rowIdx = 2'd2;
         4'b1000: w_rowIdx = 2'd3;
         default: w_rowIdx = 2'd0;
      endcase
   end

   // Keypad legend: digits encode as themselves, '*' = B, '#' = C, A never emitted.
   always_comb begin
      w_code = 4'hA;
      case ({r_capRow, r_capColIdx})
         4'b00_00: w_code = 4'h1;
         4'b00_01: w_code = 4'h2;
         4'b00_10: w_code = 4'h3;
         4'b01_00: w_code = 4'h4;
         4'b01_01: w_code = 4'h5;
         4'b01_10: w_code = 4'h6;
         4'b10_00: w_code = 4'h7;
         4'b10_01: w_code = 4'h8;
         4'b10_10: w_code = 4'h9;
         4'b11_00: w_code = 4'hB;
         4'b11_01: w_code = 4'h0;
         4'b11_10: w_code = 4'hC;
         default:  w_code = 4'hA;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= SCAN;
         r_colMeta   <= 3'b000;
         r_colSync   <= 3'b000;
         r_div       <= '0;
         r_dbCnt     <= '0;
         r_row       <= 4'b0001;
         r_capRow    <= 2'd0;
         r_capColIdx <= 2'd0;
         r_capPat    <= 3'b000;
         r_key       <= 4'hA;
         r_shift     <= 1'b0;
`ifdef KEY_REPEAT_EN
         r_repCnt    <= '0;
`endif
      end else begin
         r_colMeta <= col_in;
         r_colSync <= r_colMeta;
         r_shift   <= 1'b0;
         case (r_state)
            SCAN: begin
               if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                  r_div <= '0;
                  if (w_colValid) begin
                     r_capRow    <= w_rowIdx;
                     r_capColIdx <= w_colIdx;
                     r_capPat    <= r_colSync;
                     r_dbCnt     <= '0;
                     r_state     <= DEBOUNCE;
                  end else begin
                     r_row <= w_rowNext;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (r_colSync == r_capPat) begin
                  if (r_dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                     r_dbCnt <= '0;
                     r_state <= EMIT;
                  end else begin
                     r_dbCnt <= r_dbCnt + 1'b1;
                  end
               end else begin
                  r_dbCnt <= '0;
                  r_div   <= '0;
                  r_row   <= w_rowNext;
                  r_state <= SCAN;
               end
            end
            EMIT: begin
               r_key   <= w_code;
               r_shift <= 1'b1;
               r_dbCnt <= '0;
               r_state <= RELEASE;
`ifdef KEY_REPEAT_EN
               r_repCnt <= '0;
`endif
            end
            RELEASE: begin
               // The row stays frozen here, so a second key on another row is invisible.
               if (r_colSync == 3'b000) begin
`ifdef KEY_REPEAT_EN
                  r_repCnt <= '0;
`endif
                  if (r_dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                     r_dbCnt <= '0;
                     r_div   <= '0;
                     r_row   <= w_rowNext;
                     r_state <= SCAN;
                  end else begin
                     r_dbCnt <= r_dbCnt + 1'b1;
                  end
               end else begin
                  r_dbCnt <= '0;
`ifdef KEY_REPEAT_EN
                  if (r_colSync == r_capPat) begin
                     if (r_repCnt == REP_W'(REPEAT_CYCLES - 1)) begin
                        r_repCnt <= '0;
                        r_state  <= EMIT;
                     end else begin
                        r_repCnt <= r_repCnt + 1'b1;
                     end
                  end else begin
                     r_repCnt <= '0;
                  end
`else
                  r_state <= RELEASE;
`endif
               end
            end
            default: r_state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a keypad model,
// a vector table, hand-written corner sequences and randomized presses.

module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 3;
   localparam int REP      = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key;
   logic       shift;

   // Key at row r, column c is bit r*3+c of pressMask.
   logic [11:0] pressMask = '0;

   int checks = 0;
   int fails  = 0;
   int cycle  = 0;

   int          strobeTotal   = 0;
   logic [3:0]  lastStrobeKey = 4'hA;
   logic        prevShift     = 1'b0;
   int          backToBack    = 0;
   int          badRow        = 0;
   int          strobeCycle[$];

   keypad_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_CYCLES(REP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .col_in(col_in),
      .row_out(row_out),
      .key(key),
      .shift(shift)
   );

   always #5 clock = ~clock;

   // Passive keypad: a driven row shows the pressed keys of that row on the columns.
   always_comb begin
      col_in = 3'b000;
      for (int r = 0; r < 4; r++) begin
         if (row_out[r]) col_in = col_in | pressMask[r*3 +: 3];
      end
   end

   always @(posedge clock) cycle <= cycle + 1;

   // Strobe monitor, sampled on the falling edge away from output changes.
   always @(negedge clock) begin
      if (reset && !$onehot(row_out)) badRow = badRow + 1;
      if (shift) begin
         if (prevShift) backToBack = backToBack + 1;
         strobeTotal   = strobeTotal + 1;
         lastStrobeKey = key;
         strobeCycle.push_back(cycle);
      end
      prevShift = shift;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL globalTimeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   typedef struct {
      logic [11:0] mask;
      int          hold;
      int          rel;
      int          expStrobes;
      logic [3:0]  expKey;
   } vec_t;

   vec_t vecs[14];

   string keyChars = "123456789*0#";

   function automatic logic [3:0] modelCode(input int idx);
      byte ch;
      ch = keyChars[idx];
      if (ch == "*") return 4'hB;
      if (ch == "#") return 4'hC;
      return 4'(ch - "0");
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks = checks + 1;
      if (actual !== expected) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // With auto-repeat built in, long holds legitimately produce extra strobes.
   task automatic checkStrobes(input string name, input int got, input int expected);
      int adj;
      adj = got;
`ifdef KEY_REPEAT_EN
      if (expected > 0 && got >= expected) adj = expected;
`endif
      checkOutput(name, adj, expected);
   endtask

   task automatic applyStimulus(input logic [11:0] mask, input int hold, input int rel);
      pressMask = mask;
      tick(hold);
      pressMask = '0;
      tick(rel);
   endtask

   task automatic doReset(input int n);
      reset = 1'b0;
      tick(n);
      reset = 1'b1;
   endtask

   task automatic waitStrobe(input string name, input int maxT);
      int base;
      bit seen;
      base = strobeTotal;
      seen = 1'b0;
      for (int i = 0; i < maxT && !seen; i++) begin
         tick(1);
         if (strobeTotal != base) seen = 1'b1;
      end
      if (!seen) checkOutput(name, 0, 1);
   endtask

   task automatic waitRow(input string name, input logic [3:0] target, input int maxT);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxT && !seen; i++) begin
         tick(1);
         if (row_out == target) seen = 1'b1;
      end
      if (!seen) checkOutput(name, 0, 1);
   endtask

   int         base;
   int         n;
   int         sawRow3;
   int         qStart;
   logic [3:0] expKeyHeld;
   logic [11:0] m;

   initial begin
      vecs[0]  = '{12'h001, 35, 15, 1, 4'h1};
      vecs[1]  = '{12'h002, 35, 15, 1, 4'h2};
      vecs[2]  = '{12'h004, 35, 15, 1, 4'h3};
      vecs[3]  = '{12'h008, 35, 15, 1, 4'h4};
      vecs[4]  = '{12'h010, 35, 15, 1, 4'h5};
      vecs[5]  = '{12'h020, 35, 15, 1, 4'h6};
      vecs[6]  = '{12'h040, 35, 15, 1, 4'h7};
      vecs[7]  = '{12'h080, 35, 15, 1, 4'h8};
      vecs[8]  = '{12'h100, 35, 15, 1, 4'h9};
      vecs[9]  = '{12'h200, 35, 15, 1, 4'hB};
      vecs[10] = '{12'h400, 35, 15, 1, 4'h0};
      vecs[11] = '{12'h800, 35, 15, 1, 4'hC};
      vecs[12] = '{12'h140, 40, 15, 0, 4'hC};
      vecs[13] = '{12'h007, 40, 15, 0, 4'hC};

      $display("[TB] reset values and row rotation");
      tick(5);
      checkOutput("resetRow", row_out, 4'b0001);
      checkOutput("resetKey", key, 4'hA);
      checkOutput("resetShift", shift, 0);
      reset = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         checkOutput($sformatf("rowRotate%0d", k), row_out, 1 << ((k / 4) % 4));
      end

      $display("[TB] table-driven single keys and invalid patterns");
      for (int i = 0; i < 14; i++) begin
         base = strobeTotal;
         applyStimulus(vecs[i].mask, vecs[i].hold, vecs[i].rel);
         checkStrobes($sformatf("vec%0dStrobes", i), strobeTotal - base, vecs[i].expStrobes);
         checkOutput($sformatf("vec%0dKey", i), key, vecs[i].expKey);
      end

      $display("[TB] press latency for key 5");
      doReset(3);
      base = strobeTotal;
      pressMask = 12'h010;
      waitRow("latencyRowWait", 4'b0010, 40);
      n = 0;
      for (int i = 0; i < 30 && !shift; i++) begin
         tick(1);
         n = n + 1;
      end
      checkOutput("latencyCycles", n, 8);
      checkOutput("latencyKey", key, 4'h5);
      checkOutput("latencyRowFrozen", row_out, 4'b0010);
      tick(100 - n);
      pressMask = '0;
      tick(20);
      checkStrobes("key5Strobes", strobeTotal - base, 1);

      $display("[TB] glitch on # then clean hold");
      waitRow("glitchRowWait", 4'b1000, 40);
      base = strobeTotal;
      pressMask = 12'h800;
      tick(2);
      pressMask = '0;
      tick(12);
      checkOutput("glitchNoStrobe", strobeTotal - base, 0);
      applyStimulus(12'h800, 35, 15);
      checkStrobes("hashStrobes", strobeTotal - base, 1);
      checkOutput("hashKey", lastStrobeKey, 4'hC);

      $display("[TB] two columns on row 2");
      base = strobeTotal;
      sawRow3 = 0;
      pressMask = 12'h140;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (row_out == 4'b1000) sawRow3 = 1;
      end
      pressMask = '0;
      tick(15);
      checkOutput("dualColNoStrobe", strobeTotal - base, 0);
      checkOutput("dualColKeyKept", key, 4'hC);
      checkOutput("dualColScanning", sawRow3, 1);

      $display("[TB] key 1 held, key 9 added");
      base = strobeTotal;
      pressMask = 12'h001;
      waitStrobe("key1Wait", 40);
      pressMask = 12'h101;
      tick(30);
      pressMask = '0;
      tick(20);
      checkStrobes("twoKeyStrobes", strobeTotal - base, 1);
      checkOutput("twoKeyLast", lastStrobeKey, 4'h1);

      $display("[TB] reset during RELEASE with key 7 held");
      pressMask = 12'h040;
      waitStrobe("key7Wait", 40);
      tick(2);
      base = strobeTotal;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checkOutput($sformatf("midResetKey%0d", i), key, 4'hA);
         checkOutput($sformatf("midResetShift%0d", i), shift, 0);
      end
      reset = 1'b1;
      checkOutput("midResetNoStrobe", strobeTotal - base, 0);
      base = strobeTotal;
      tick(40);
      pressMask = '0;
      tick(20);
      checkStrobes("afterResetStrobes", strobeTotal - base, 1);
      checkOutput("afterResetKey", lastStrobeKey, 4'h7);
      expKeyHeld = 4'h7;

      $display("[TB] randomized presses against the reference model");
      for (int it = 0; it < 24; it++) begin
         int kind;
         int idx;
         int row;
         int c0;
         int c1;
         kind = $urandom_range(0, 2);
         base = strobeTotal;
         if (kind == 0) begin
            idx = $urandom_range(0, 11);
            applyStimulus(12'(1 << idx), $urandom_range(30, 40), $urandom_range(12, 25));
            expKeyHeld = modelCode(idx);
            checkStrobes($sformatf("rand%0dStrobes", it), strobeTotal - base, 1);
            checkOutput($sformatf("rand%0dStrobeKey", it), lastStrobeKey, expKeyHeld);
         end else if (kind == 1) begin
            row = $urandom_range(0, 3);
            c0 = $urandom_range(0, 2);
            c1 = (c0 + $urandom_range(1, 2)) % 3;
            m = 12'(1 << (row * 3 + c0)) | 12'(1 << (row * 3 + c1));
            applyStimulus(m, $urandom_range(30, 40), $urandom_range(12, 25));
            checkOutput($sformatf("rand%0dMultiNone", it), strobeTotal - base, 0);
         end else begin
            idx = $urandom_range(0, 11);
            applyStimulus(12'(1 << idx), $urandom_range(1, 2), $urandom_range(12, 25));
            checkOutput($sformatf("rand%0dGlitchNone", it), strobeTotal - base, 0);
         end
         checkOutput($sformatf("rand%0dKeyHeld", it), key, expKeyHeld);
      end

`ifdef KEY_REPEAT_EN
      $display("[TB] auto-repeat spacing");
      doReset(3);
      qStart = strobeCycle.size();
      applyStimulus(12'h040, 60, 20);
      checkOutput("repeatAtLeastTwo", (strobeCycle.size() - qStart) >= 2, 1);
      for (int i = qStart + 1; i < strobeCycle.size(); i++) begin
         checkOutput($sformatf("repeatGap%0d", i - qStart), strobeCycle[i] - strobeCycle[i-1], REP + 1);
      end
      checkOutput("repeatKey", lastStrobeKey, 4'h7);
`endif

      checkOutput("noBackToBackShift", backToBack, 0);
      checkOutput("rowAlwaysOneHot", badRow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
